// File: rtl/legofpga_mac_cfg_seq.sv
// MAC/PHY bring-up sequencer: PHY reset and settle, then a fixed 4-bit command list over valid/ready.
// Optional feature: define MAC_CFG_AUTOSTART_EN to issue commands right after PHY settle.
module legofpga_mac_cfg_seq #(
    parameter int unsigned PHY_RST_CYCLES  = 1250,
    parameter int unsigned PHY_WAIT_CYCLES = 12500,
    parameter int unsigned NUM_CMDS        = 4,
    parameter int unsigned CMD_TIMEOUT     = 255,
    localparam int unsigned IDX_W = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                    clk_125,
    input  logic                    sys_rst,
    input  logic                    start_config,
    input  logic [4*NUM_CMDS-1:0]   cmd_list,
    output logic                    phy_rst_n,
    output logic [3:0]              control_data,
    output logic                    control_valid,
    input  logic                    control_ready,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_error,
    output logic [IDX_W-1:0]        cmd_idx
);

    localparam int unsigned CNT_MAX = (PHY_RST_CYCLES > PHY_WAIT_CYCLES) ?
                                      PHY_RST_CYCLES : PHY_WAIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMO_W   = $clog2(CMD_TIMEOUT + 2);

    typedef enum logic [2:0] {
        StPhyRst,
        StPhyWait,
        StIdle,
        StIssue,
        StDone,
        StErr
    } state_e;

    state_e             r_state, w_state_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [TMO_W-1:0]   r_tmo, w_tmo_d;
    logic               r_start_s, r_start_q;
    logic               r_phy_rst_n, w_phy_rst_n_d;
    logic [3:0]         r_data, w_data_d;
    logic               r_valid, w_valid_d;
    logic               r_busy, w_busy_d;
    logic               r_done, w_done_d;
    logic               r_error, w_error_d;
    logic [IDX_W-1:0]   r_idx, w_idx_d;

    logic               w_start_rise;
    logic               w_enter_issue;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [TMO_W-1:0]   w_tmo_inc;

    // Edge detect runs off a registered sample so no input reaches an output combinationally.
    assign w_start_rise = r_start_s & ~r_start_q;
    assign w_idx_inc    = r_idx + 1'b1;
    assign w_tmo_inc    = r_tmo + 1'b1;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_tmo_d       = r_tmo;
        w_phy_rst_n_d = r_phy_rst_n;
        w_data_d      = r_data;
        w_valid_d     = r_valid;
        w_busy_d      = r_busy;
        w_done_d      = r_done;
        w_error_d     = r_error;
        w_idx_d       = r_idx;
        w_enter_issue = 1'b0;

        case (r_state)
            StPhyRst: begin
                if (r_cnt == CNT_W'(PHY_RST_CYCLES - 1)) begin
                    w_state_d     = StPhyWait;
                    w_cnt_d       = '0;
                    w_phy_rst_n_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StPhyWait: begin
                if (r_cnt == CNT_W'(PHY_WAIT_CYCLES - 1)) begin
`ifdef MAC_CFG_AUTOSTART_EN
                    w_enter_issue = 1'b1;
`else
                    w_state_d = StIdle;
                    w_busy_d  = 1'b0;
`endif
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StIdle, StDone, StErr: begin
                if (w_start_rise) begin
                    w_enter_issue = 1'b1;
                end
            end
            StIssue: begin
                // A transfer on the would-be timeout cycle takes priority over the error.
                if (r_valid && control_ready) begin
                    if (r_idx < IDX_W'(NUM_CMDS - 1)) begin
                        w_idx_d  = w_idx_inc;
                        w_data_d = cmd_list[{w_idx_inc, 2'b00} +: 4];
                        w_tmo_d  = '0;
                    end else begin
                        w_state_d = StDone;
                        w_valid_d = 1'b0;
                        w_busy_d  = 1'b0;
                        w_done_d  = 1'b1;
                    end
                end else if (r_valid) begin
                    w_tmo_d = w_tmo_inc;
                    if (w_tmo_inc >= TMO_W'(CMD_TIMEOUT)) begin
                        w_state_d = StErr;
                        w_valid_d = 1'b0;
                        w_busy_d  = 1'b0;
                        w_error_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StPhyRst;
            end
        endcase

        if (w_enter_issue) begin
            w_state_d = StIssue;
            w_idx_d   = '0;
            w_valid_d = 1'b1;
            w_data_d  = cmd_list[3:0];
            w_busy_d  = 1'b1;
            w_done_d  = 1'b0;
            w_error_d = 1'b0;
            w_tmo_d   = '0;
        end
    end

    always_ff @(posedge clk_125 or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= StPhyRst;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_start_s   <= 1'b0;
            r_start_q   <= 1'b0;
            r_phy_rst_n <= 1'b0;
            r_data      <= 4'h0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_tmo       <= w_tmo_d;
            r_start_s   <= start_config;
            r_start_q   <= r_start_s;
            r_phy_rst_n <= w_phy_rst_n_d;
            r_data      <= w_data_d;
            r_valid     <= w_valid_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_error     <= w_error_d;
            r_idx       <= w_idx_d;
        end
    end

    assign phy_rst_n     = r_phy_rst_n;
    assign control_data  = r_data;
    assign control_valid = r_valid;
    assign cfg_busy      = r_busy;
    assign cfg_done      = r_done;
    assign cfg_error     = r_error;
    assign cmd_idx       = r_idx;

endmodule

// File: doc/legofpga_mac_cfg_seq.md
# legofpga_mac_cfg_seq

Bring-up and configuration sequencer for the AXI Ethernet MAC/PHY in the LegoFPGA top level. It holds the PHY in reset for a fixed time, waits for the PHY to settle, then drives a fixed list of 4-bit commands into the MAC control port over a valid/ready handshake. It reports busy, done and error status. The block runs in the 125 MHz domain next to the MAC wrapper and replaces free-running board-pin control of `control_*` and `phy_rst_n`.

## Interface
Parameters:
- `PHY_RST_CYCLES`, 1250: cycles `phy_rst_n` is held low after reset (10 us at 125 MHz); must be ≥1.
- `PHY_WAIT_CYCLES`, 12500: settle cycles after `phy_rst_n` rises; must be ≥1.
- `NUM_CMDS`, 4: number of commands in `cmd_list`; must be ≥1.
- `CMD_TIMEOUT`, 255: maximum cycles `control_valid` may wait for `control_ready`.

Ports:
- `clk_125`  in  1  sole clock; one clock, no CDC inside.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `start_config`  in  1  request level; the rising edge starts or restarts the sequence.
- `cmd_list`  in  4*NUM_CMDS  command nibbles; command k is `[4k+3:4k]`; quasi-static.
- `phy_rst_n`  out  1  PHY reset, active low.
- `control_data`  out  4  current command.
- `control_valid`  out  1  command valid.
- `control_ready`  in  1  MAC accepts the command.
- `cfg_busy`  out  1  high in PHY_RST, PHY_WAIT and ISSUE.
- `cfg_done`  out  1  sticky; the whole list was accepted.
- `cfg_error`  out  1  sticky; a handshake timed out.
- `cmd_idx`  out  max(1,$clog2(NUM_CMDS))  index of the current or failing command.

## Operation
- States: PHY_RST → PHY_WAIT → IDLE → ISSUE → DONE | ERR. DONE and ERR return to ISSUE on a `start_config` rising edge.
- PHY_RST:
  - `phy_rst_n`=0 and the counter increments.
  - At count PHY_RST_CYCLES-1, go to PHY_WAIT and clear the counter.
- PHY_WAIT:
  - `phy_rst_n`=1.
  - At count PHY_WAIT_CYCLES-1, go to IDLE.
- IDLE: wait for a `start_config` rising edge, detected against a registered copy of `start_config`.
- Entering ISSUE:
  - `cmd_idx`=0, `control_valid`=1, `control_data`=`cmd_list[3:0]`.
  - Clear `cfg_done`/`cfg_error` and the timeout counter.
- ISSUE handshake:
  - A transfer occurs on a cycle with `control_valid`&&`control_ready`.
  - `control_data` stays stable while valid and not ready.
  - On a transfer with `cmd_idx`<NUM_CMDS-1: increment `cmd_idx`, present the next nibble on the following cycle, keep valid high (back-to-back), and clear the timeout counter.
  - On a transfer of the last command: go to DONE, drop valid, set `cfg_done`.
- Timeout:
  - The counter increments on each cycle with valid && !ready.
  - When it reaches CMD_TIMEOUT without a transfer: go to ERR, drop valid, set `cfg_error`, and freeze `cmd_idx` at the failing command.
- `start_config` edges in PHY_RST, PHY_WAIT or ISSUE are ignored (not queued).
- The edge-detect register updates in every state, so a level already high at entry to IDLE does not start the sequence.
- `phy_rst_n` is never re-asserted except by `sys_rst`.

## Timing
- Reset values:
  - `phy_rst_n`=0, `control_valid`=0, `control_data`=0.
  - `cfg_busy`=1, `cfg_done`=0, `cfg_error`=0, `cmd_idx`=0.
  - State is PHY_RST and all counters are 0.
- After `sys_rst` deasserts:
  - `phy_rst_n` is low for exactly PHY_RST_CYCLES rising edges.
  - IDLE is reached PHY_WAIT_CYCLES edges after that.
- Start latency: an edge sampled at edge n gives `control_valid`=1 after edge n+1.
- Throughput: with `control_ready` held high, NUM_CMDS commands take NUM_CMDS cycles. `cfg_done` rises at the edge that accepts the last command.
- Ready arriving on the timeout cycle: the transfer wins and no error is raised.
- `sys_rst` mid-operation: immediate return to the reset values. `control_valid` drops asynchronously.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `MAC_CFG_AUTOSTART_EN` defined: PHY_WAIT goes directly to ISSUE with no `start_config` needed. Later `start_config` edges in DONE/ERR still restart the sequence.
- Not defined: PHY_WAIT goes to IDLE and waits for `start_config` as described above.

## Test plan
Bench parameters: PHY_RST_CYCLES=4, PHY_WAIT_CYCLES=8, NUM_CMDS=3, CMD_TIMEOUT=5, `cmd_list`=12'hA53.
- Release `sys_rst` -> `phy_rst_n` low for 4 cycles, high thereafter; `cfg_busy` drops 8 cycles later; `control_valid` stays 0.
- Pulse `start_config` in IDLE, `control_ready` tied 1 -> `control_valid` high 2 edges later for 3 cycles with data 3,5,A; `cfg_done`=1 and `cfg_busy`=0 after the last transfer.
- `control_ready` toggles 0,1 each cycle -> data held while not ready; each nibble transferred exactly once; `cfg_done`=1.
- `control_ready` stuck 0 on command 1 -> `cfg_error`=1 after 5 waiting cycles; `cmd_idx`=1; `control_valid`=0; a new `start_config` edge restarts at `cmd_idx`=0 and clears `cfg_error`.
- Assert `sys_rst` during ISSUE at `cmd_idx`=1 -> all outputs return to reset values immediately; the PHY_RST sequence repeats.
- Build with `MAC_CFG_AUTOSTART_EN` and `start_config`=0 -> commands 3,5,A issued right after PHY_WAIT; `cfg_done`=1.
